// File: rtl/axi_read_master.sv
// Single-outstanding AXI4 read master: issues one AR request per command and
// streams the R beats to a local consumer, then reports response/length errors.
module axi_read_master #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8,
   parameter int SIZE_W = 3,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [SIZE_W-1:0] cmd_size,
   input  logic [1:0]        cmd_burst,
   output logic [ADDR_W-1:0] araddr,
   output logic [LEN_W-1:0]  arlen,
   output logic [SIZE_W-1:0] arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   output logic              rready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_resp,
   output logic              out_last,
   input  logic              out_ready,
   output logic              done,
   output logic              resp_err,
   output logic              len_err,
   output logic              busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [LEN_W:0] CNT_ONE = 1;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [LEN_W-1:0]  arlen_q, arlen_d;
   logic [SIZE_W-1:0] arsize_q, arsize_d;
   logic [1:0]        arburst_q, arburst_d;
   logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
   logic              resp_err_q, resp_err_d;
   logic              len_err_q, len_err_d;
   logic              in_data;
   logic              beat_hs;

   assign in_data = (state_q == S_DATA);
   assign beat_hs = in_data && rvalid && out_ready;

   always_comb begin
      state_d    = state_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arsize_d   = arsize_q;
      arburst_d  = arburst_q;
      beat_cnt_d = beat_cnt_q;
      resp_err_d = resp_err_q;
      len_err_d  = len_err_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               araddr_d   = cmd_addr;
               arlen_d    = cmd_len;
               arsize_d   = cmd_size;
               arburst_d  = cmd_burst;
               beat_cnt_d = '0;
               resp_err_d = 1'b0;
               len_err_d  = 1'b0;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            if (arready) state_d = S_DATA;
         end
         S_DATA: begin
            if (beat_hs) begin
               // counter saturates rather than wrapping on runaway bursts
               if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CNT_ONE;
               if (rresp != 2'b00) resp_err_d = 1'b1;
               if (rlast) begin
                  if (beat_cnt_q != {1'b0, arlen_q}) len_err_d = 1'b1;
                  state_d = S_DONE;
               end else if (beat_cnt_q >= {1'b0, arlen_q}) begin
                  len_err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
         arburst_q  <= '0;
         beat_cnt_q <= '0;
         resp_err_q <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arsize_q   <= arsize_d;
         arburst_q  <= arburst_d;
         beat_cnt_q <= beat_cnt_d;
         resp_err_q <= resp_err_d;
         len_err_q  <= len_err_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign arvalid   = (state_q == S_ADDR);
   assign done      = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arsize    = arsize_q;
   assign arburst   = arburst_q;
   assign rready    = in_data && out_ready;
   assign out_valid = in_data && rvalid;
   assign out_data  = rdata;
   assign out_resp  = rresp;
   assign out_last  = rlast;
   assign resp_err  = resp_err_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: stimulus pushes expected beats and
// completion status into queues, a negedge monitor pops and compares them.
module tb_axi_read_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [1:0]  cmd_burst;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_resp;
   logic        out_last;
   logic        out_ready;
   logic        done;
   logic        resp_err;
   logic        len_err;
   logic        busy;

   axi_read_master #(.ADDR_W(32), .LEN_W(8), .SIZE_W(3), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready),
      .out_valid(out_valid), .out_data(out_data), .out_resp(out_resp),
      .out_last(out_last), .out_ready(out_ready),
      .done(done), .resp_err(resp_err), .len_err(len_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
   } beat_t;

   beat_t      bq[$];
   logic [1:0] cq[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         done_seen = 0;
   logic       in_data = 1'b0;
   logic       tog_en = 1'b0;

   logic [31:0] exp_addr;
   logic [7:0]  exp_len;
   logic [2:0]  exp_size;
   logic [1:0]  exp_burst;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = tog_en ? ~out_ready : 1'b1;
   end

   always @(negedge clk) begin
      check("rready_mirror", {63'd0, rready}, {63'd0, in_data & out_ready});
      check("out_valid_gate", {63'd0, out_valid}, {63'd0, in_data & rvalid});
      if (out_valid && out_ready) begin
         if (bq.size() == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
         end else begin
            beat_t e;
            e = bq.pop_front();
            check("out_data", {32'd0, out_data}, {32'd0, e.d});
            check("out_resp", {62'd0, out_resp}, {62'd0, e.r});
            check("out_last", {63'd0, out_last}, {63'd0, e.l});
         end
      end
      if (done) begin
         done_seen++;
         if (cq.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            logic [1:0] c;
            c = cq.pop_front();
            check("resp_err", {63'd0, resp_err}, {63'd0, c[1]});
            check("len_err", {63'd0, len_err}, {63'd0, c[0]});
         end
      end
   end

   task automatic check_ar(input string name);
      check({name, "_arvalid"}, {63'd0, arvalid}, 64'd1);
      check({name, "_araddr"}, {32'd0, araddr}, {32'd0, exp_addr});
      check({name, "_arlen"}, {56'd0, arlen}, {56'd0, exp_len});
      check({name, "_arsize"}, {61'd0, arsize}, {61'd0, exp_size});
      check({name, "_arburst"}, {62'd0, arburst}, {62'd0, exp_burst});
   endtask

   // delay==0 presents arready before arvalid so the handshake is immediate
   task automatic run_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input int delay, input logic re, input logic le);
      logic hs;
      int   n;
      exp_addr = a; exp_len = l; exp_size = s; exp_burst = b;
      cq.push_back({re, le});
      cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
      cmd_valid = 1'b1;
      arready = (delay == 0);
      hs = 1'b0;
      n = 0;
      while (!hs && n < 50) begin
         @(negedge clk); hs = cmd_ready;
         @(posedge clk); #1;
         n++;
      end
      cmd_valid = 1'b0;
      cmd_addr = '1; cmd_len = '1; cmd_size = '1; cmd_burst = '1;
      if (!hs) check("cmd_timeout", 64'd0, 64'd1);
      @(negedge clk);
      check_ar("ar_rise");
      check("err_clear", {62'd0, resp_err, len_err}, 64'd0);
      for (int i = 1; i <= delay; i++) begin
         @(posedge clk); #1;
         if (i == delay) arready = 1'b1;
         @(negedge clk);
         check_ar("ar_wait");
      end
      @(posedge clk); #1;
      arready = 1'b0;
      in_data = 1'b1;
      @(negedge clk);
      check("ar_drop", {63'd0, arvalid}, 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [1:0] r, input logic l);
      beat_t e;
      logic  hs;
      int    n;
      e.d = d; e.r = r; e.l = l;
      bq.push_back(e);
      rvalid = 1'b1; rdata = d; rresp = r; rlast = l;
      hs = 1'b0;
      n = 0;
      while (!hs && n < 50) begin
         @(negedge clk); hs = rready;
         @(posedge clk); #1;
         n++;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (!hs) check("beat_timeout", 64'd0, 64'd1);
      if (l) in_data = 1'b0;
   endtask

   task automatic finish_txn();
      @(negedge clk);
      check("done_pulse", {61'd0, done, busy, cmd_ready}, {61'd0, 3'b110});
      @(posedge clk); #1;
      @(negedge clk);
      check("done_end", {61'd0, done, busy, cmd_ready}, {61'd0, 3'b001});
      @(posedge clk); #1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_ctl"}, {58'd0, arvalid, rready, busy, cmd_ready, done, out_valid},
            {58'd0, 6'b000100});
      check({name, "_err"}, {62'd0, resp_err, len_err}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
      cmd_burst = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      rlast = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_idle("reset");
      check("reset_ar", {23'd0, araddr, arlen, arsize, arburst}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // single beat, arready already high
      run_ar(32'h1000, 8'd0, 3'd2, 2'd1, 0, 1'b0, 1'b0);
      send_beat(32'hDEADBEEF, 2'b00, 1'b1);
      finish_txn();

      // 4-beat INCR, arready delayed 3 cycles
      run_ar(32'h2000, 8'd3, 3'd2, 2'd1, 3, 1'b0, 1'b0);
      send_beat(32'h11, 2'b00, 1'b0);
      send_beat(32'h22, 2'b00, 1'b0);
      send_beat(32'h33, 2'b00, 1'b0);
      send_beat(32'h44, 2'b00, 1'b1);
      finish_txn();

      // consumer backpressure
      tog_en = 1'b1;
      run_ar(32'h2400, 8'd3, 3'd2, 2'd1, 1, 1'b0, 1'b0);
      send_beat(32'hA0A0_0001, 2'b00, 1'b0);
      send_beat(32'hA0A0_0002, 2'b00, 1'b0);
      send_beat(32'hA0A0_0003, 2'b00, 1'b0);
      send_beat(32'hA0A0_0004, 2'b00, 1'b1);
      finish_txn();
      tog_en = 1'b0;
      @(posedge clk); #1;

      // error response on the second beat, reserved burst passed through
      run_ar(32'h0000_0040, 8'd1, 3'd1, 2'b11, 2, 1'b1, 1'b0);
      send_beat(32'h5555_0000, 2'b00, 1'b0);
      send_beat(32'h5555_0001, 2'b10, 1'b1);
      finish_txn();

      // early rlast
      run_ar(32'hFFFF_FFFC, 8'd3, 3'd2, 2'd1, 0, 1'b0, 1'b1);
      send_beat(32'h0BAD_0001, 2'b00, 1'b0);
      send_beat(32'h0BAD_0002, 2'b00, 1'b1);
      finish_txn();

      // overrun: len=0 but rlast only on beat 2
      run_ar(32'h3000, 8'd0, 3'd2, 2'd0, 1, 1'b0, 1'b1);
      send_beat(32'hC0DE_0001, 2'b00, 1'b0);
      send_beat(32'hC0DE_0002, 2'b01, 1'b1);
      cq[0] = 2'b11;
      finish_txn();

      // reset in DATA after the first beat
      run_ar(32'h4000, 8'd3, 3'd2, 2'd1, 0, 1'b0, 1'b0);
      void'(cq.pop_back());
      send_beat(32'h7777_0001, 2'b10, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      in_data = 1'b0;
      @(negedge clk);
      check_idle("mid_reset");
      @(posedge clk); #1;

      // command coincident with reset is dropped
      reset = 1'b1; cmd_valid = 1'b1; cmd_addr = 32'h9999_0000;
      @(posedge clk); #1;
      reset = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      check_idle("reset_cmd");
      @(posedge clk); #1;

      run_ar(32'h5000, 8'd1, 3'd2, 2'd1, 1, 1'b0, 1'b0);
      send_beat(32'h1234_5678, 2'b00, 1'b0);
      send_beat(32'h9ABC_DEF0, 2'b00, 1'b1);
      finish_txn();

      repeat (2) @(posedge clk);
      check("done_count", 64'(done_seen), 64'd7);
      check("beats_left", 64'(bq.size()), 64'd0);
      check("comps_left", 64'(cq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
Single-outstanding AXI4 read master that drives the AR/R side of the `axi_slave_if` `dut` modport. It accepts one read command at a time and issues it on the AR channel. It then streams the returned R beats to a local consumer with backpressure, and reports completion plus response and length errors. It sits between a local requester (DMA/test sequencer) and the AXI interconnect slave port.

Parameters:
ADDR_W, 32, address width
LEN_W, 8, burst length field width (beats = len+1)
SIZE_W, 3, burst size field width
DATA_W, 32, read data width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  beats minus one
cmd_size  in  SIZE_W  bytes per beat = 2^size
cmd_burst  in  2  burst type, passed through
araddr  out  ADDR_W  AR address
arlen  out  LEN_W  AR length
arsize  out  SIZE_W  AR size
arburst  out  2  AR burst
arvalid  out  1  AR valid
arready  in  1  AR ready
rvalid  in  1  R valid
rdata  in  DATA_W  R data
rresp  in  2  R response
rlast  in  1  R last
rready  out  1  R ready
out_valid  out  1  beat to consumer
out_data  out  DATA_W  beat data
out_resp  out  2  beat response
out_last  out  1  final beat of the transaction
out_ready  in  1  consumer ready
done  out  1  one-cycle completion pulse
resp_err  out  1  status for completed transaction; valid while done=1, held until next command
len_err  out  1  beat count and rlast mismatch; valid while done=1, held until next command
busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, arvalid=0, rready=0, done=0, resp_err=0, len_err=0, busy=0, cmd_ready=1. AR address/len/size/burst registers are cleared to 0.
- FSM: IDLE -> ADDR -> DATA -> DONE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/len/size/burst into the AR registers, clear the beat counter, resp_err and len_err, and go to ADDR.
  - arvalid rises the cycle after acceptance.
- ADDR:
  - arvalid=1; araddr/arlen/arsize/arburst stay stable until arready is sampled high.
  - On arvalid&&arready, go to DATA; arvalid deasserts the next cycle.
  - Latency from arvalid to arready is unbounded.
  - arready high before arvalid has no effect.
  - Burst is issued exactly as commanded; reserved 2'b11 is not checked.
- DATA:
  - rready = out_ready (combinational).
  - out_valid = rvalid; out_data = rdata; out_resp = rresp; out_last = rlast (combinational pass-through).
  - Outside DATA: rready=0 and out_valid=0.
  - A beat is accepted on rvalid&&rready. Each accepted beat increments the beat counter (LEN_W+1 bits, no wrap).
  - Any accepted beat with rresp != 2'b00 sets resp_err (sticky for the transaction).
  - Accepted beat with rlast=1: set len_err if counter != arlen, then go to DONE.
  - If the counter exceeds arlen without rlast, set len_err and keep accepting until rlast.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. A new command can be accepted the cycle after DONE.
- Only one transaction is outstanding. ARID is not used; R beats are never expected outside DATA and are ignored there (rready=0).
- Reset mid-transaction: the next cycle is in IDLE with all outputs at reset values. No draining of pending R beats.
- Simultaneous cmd_valid and reset: reset wins, the command is not accepted.

Test Plan:
- Single beat: cmd addr=0x1000, len=0, size=2, burst=1; arready high immediately; one R beat 0xDEADBEEF, rresp=0, rlast=1 -> arvalid 1 cycle; out_data=0xDEADBEEF with out_last=1; done pulse; resp_err=0; len_err=0.
- 4-beat INCR with arready delayed 3 cycles -> AR fields stable across the wait; beats 0x11..0x44 delivered in order; last on beat 4; done 1 cycle after the final handshake.
- Backpressure: len=3, out_ready toggles 1/0 each cycle -> rready mirrors out_ready; no beat lost or duplicated; 4 beats total.
- Error response: len=1, second beat rresp=2'b10 -> out_resp=2 on that beat; resp_err=1 at done; len_err=0.
- Length mismatch: len=3, rlast on beat 2 -> transaction ends after 2 beats; len_err=1. Separately, len=0 with rlast on beat 2 -> both beats accepted; len_err=1.
- Reset asserted in DATA after beat 1 -> next cycle arvalid=0, rready=0, busy=0, cmd_ready=1; a subsequent command completes normally.
